// File: rtl/raster_stamp_csr.sv
// raster_stamp_csr: consumer-side endpoint of the rasterizer stamp stream.
//
// Stamps arrive from the raster unit and are queued in a small FIFO. On a core
// pop request, the head stamp is latched into the current CSR set. The core then
// reads that set word by word through a registered CSR read port.
//
// Handshakes:
//   - Push: a stamp transfers on a cycle with stamp_valid & stamp_ready.
//   - Pop:  a request transfers on a cycle with req_valid & req_ready.
//   - A transferred pop produces exactly one rsp_valid pulse in the following
//     cycle. rsp_done qualifies that pulse.
//   - A full FIFO never accepts a push, even in a cycle where a pop drains it.
//
// Optional feature macro: RASTER_STAMP_BYPASS_EN. When defined, a stamp offered
// to an empty FIFO can be forwarded straight into the current set in the same
// cycle as a pop.
//
// Packed stamp layout, MSB first (436 bits):
//   pos_x[15:0], pos_y[15:0], mask[3:0],
//   bcoord_x[3:0][31:0], bcoord_y[3:0][31:0], bcoord_z[3:0][31:0], pid[15:0]
// Element 0 of each bcoord array sits in the low 32 bits of that field.
module raster_stamp_csr #(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stamp_valid,
  input  logic [435:0] stamp_data,
  output logic         stamp_ready,
  input  logic         raster_done,
  input  logic         req_valid,
  output logic         req_ready,
  output logic         rsp_valid,
  output logic         rsp_done,
  input  logic         csr_read_valid,
  input  logic [3:0]   csr_read_addr,
  output logic [31:0]  csr_read_data,
  input  logic         csr_write_valid,
  input  logic [3:0]   csr_write_addr,
  input  logic [31:0]  csr_write_data
);

  localparam int SW = 436;
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = PW + 1;

  // Bit offsets of the stamp fields inside the packed word
  localparam int POS_X_LSB = 420;
  localparam int POS_Y_LSB = 404;
  localparam int MASK_LSB  = 400;
  localparam int BX_LSB    = 272;
  localparam int BY_LSB    = 144;
  localparam int BZ_LSB    = 16;

  logic [SW-1:0] r_mem [QUEUE_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_cur;
  logic [31:0]   r_grad_x;
  logic [31:0]   r_grad_y;
  logic          r_rsp_valid;
  logic          r_rsp_done;
  logic [31:0]   r_rd_data;

  logic          w_empty;
  logic          w_full;
  logic          w_bypass;
  logic          w_pop;
  logic          w_deq;
  logic          w_fwd;
  logic          w_done;
  logic          w_push;
  logic [31:0]   w_rd_word;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(QUEUE_DEPTH));

`ifdef RASTER_STAMP_BYPASS_EN
  // An offered stamp can be delivered directly when nothing is queued ahead of it
  assign w_bypass = w_empty & stamp_valid;
`else
  assign w_bypass = 1'b0;
`endif

  // Ready signals are held low while reset is asserted
  assign stamp_ready = ~reset & ~w_full;
  assign req_ready   = ~reset & (~w_empty | w_bypass | raster_done);

  // Pop classification: dequeue, forward, or report done (forward beats done)
  assign w_pop  = req_valid & req_ready;
  assign w_deq  = w_pop & ~w_empty;
  assign w_fwd  = w_pop & w_empty & w_bypass;
  assign w_done = w_pop & w_empty & ~w_bypass;

  // A forwarded stamp is consumed without ever touching the FIFO
  assign w_push = stamp_valid & stamp_ready & ~w_fwd;

  // FIFO storage; contents need no reset because pointers and count gate them
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= stamp_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= PW'((32'(r_wr_ptr) + 1) % QUEUE_DEPTH);
      if (w_deq)  r_rd_ptr <= PW'((32'(r_rd_ptr) + 1) % QUEUE_DEPTH);
      case ({w_push, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Current CSR set, loaded from the FIFO head or from the forwarded stamp
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur <= '0;
    end else if (w_deq) begin
      r_cur <= r_mem[r_rd_ptr];
    end else if (w_fwd) begin
      r_cur <= stamp_data;
    end
  end

  // Gradient registers, written only through the CSR write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grad_x <= '0;
      r_grad_y <= '0;
    end else if (csr_write_valid) begin
      if (csr_write_addr == 4'd14) r_grad_x <= csr_write_data;
      if (csr_write_addr == 4'd15) r_grad_y <= csr_write_data;
    end
  end

  // One-cycle response pulse following each accepted pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_done  <= 1'b0;
    end else begin
      r_rsp_valid <= w_pop;
      r_rsp_done  <= w_done;
    end
  end

  // CSR word select from the current set (pre-update values)
  always_comb begin
    w_rd_word = '0;
    case (csr_read_addr)
      4'd0:  w_rd_word = {r_cur[POS_Y_LSB +: 16], r_cur[POS_X_LSB +: 16]};
      4'd1:  w_rd_word = {r_cur[15:0], 12'b0, r_cur[MASK_LSB +: 4]};
      4'd2:  w_rd_word = r_cur[BX_LSB + 0  +: 32];
      4'd3:  w_rd_word = r_cur[BX_LSB + 32 +: 32];
      4'd4:  w_rd_word = r_cur[BX_LSB + 64 +: 32];
      4'd5:  w_rd_word = r_cur[BX_LSB + 96 +: 32];
      4'd6:  w_rd_word = r_cur[BY_LSB + 0  +: 32];
      4'd7:  w_rd_word = r_cur[BY_LSB + 32 +: 32];
      4'd8:  w_rd_word = r_cur[BY_LSB + 64 +: 32];
      4'd9:  w_rd_word = r_cur[BY_LSB + 96 +: 32];
      4'd10: w_rd_word = r_cur[BZ_LSB + 0  +: 32];
      4'd11: w_rd_word = r_cur[BZ_LSB + 32 +: 32];
      4'd12: w_rd_word = r_cur[BZ_LSB + 64 +: 32];
      4'd13: w_rd_word = r_cur[BZ_LSB + 96 +: 32];
      4'd14: w_rd_word = r_grad_x;
      4'd15: w_rd_word = r_grad_y;
      default: w_rd_word = '0;
    endcase
  end

  // Registered read data, held until the next read strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (csr_read_valid) begin
      r_rd_data <= w_rd_word;
    end
  end

  assign rsp_valid     = r_rsp_valid;
  assign rsp_done      = r_rsp_done;
  assign csr_read_data = r_rd_data;

endmodule

// File: tb/tb_raster_stamp_csr.sv
// Directed bench for raster_stamp_csr (QUEUE_DEPTH = 4).
// Inputs change on the falling edge; outputs are sampled just after it.
module tb_raster_stamp_csr;

  logic         clk = 1'b0;
  logic         reset;
  logic         stamp_valid;
  logic [435:0] stamp_data;
  logic         stamp_ready;
  logic         raster_done;
  logic         req_valid;
  logic         req_ready;
  logic         rsp_valid;
  logic         rsp_done;
  logic         csr_read_valid;
  logic [3:0]   csr_read_addr;
  logic [31:0]  csr_read_data;
  logic         csr_write_valid;
  logic [3:0]   csr_write_addr;
  logic [31:0]  csr_write_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;

  raster_stamp_csr #(.QUEUE_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .stamp_valid(stamp_valid), .stamp_data(stamp_data), .stamp_ready(stamp_ready),
    .raster_done(raster_done),
    .req_valid(req_valid), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_done(rsp_done),
    .csr_read_valid(csr_read_valid), .csr_read_addr(csr_read_addr),
    .csr_read_data(csr_read_data),
    .csr_write_valid(csr_write_valid), .csr_write_addr(csr_write_addr),
    .csr_write_data(csr_write_data)
  );

  // Clock
  always #5 clk = ~clk;

  // Build a packed stamp from its interesting fields
  function automatic logic [435:0] mk(input logic [15:0] px, input logic [15:0] py,
                                      input logic [3:0] m, input logic [15:0] pid,
                                      input logic [31:0] bx0, input logic [31:0] bz3);
    logic [435:0] s;
    s = '0;
    s[435:420]    = px;
    s[419:404]    = py;
    s[403:400]    = m;
    s[272 +: 32]  = bx0;
    s[112 +: 32]  = bz3;
    s[15:0]       = pid;
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reset block: holds reset two cycles and checks outputs while it is asserted
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_stamp_ready", {31'b0, stamp_ready}, 0);
    check("rst_req_ready", {31'b0, req_ready}, 0);
    @(negedge clk);
    @(negedge clk);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("rst_rsp_done", {31'b0, rsp_done}, 0);
    check("rst_rd_data", csr_read_data, 0);
    reset = 1'b0;
  endtask

  // Driver tasks: entered at a falling edge, return at a later falling edge
  task automatic push(input logic [435:0] d);
    stamp_valid = 1'b1;
    stamp_data  = d;
    #1;
    check("push_ready", {31'b0, stamp_ready}, 1);
    @(negedge clk);
    stamp_valid = 1'b0;
  endtask

  task automatic pop(input logic exp_done);
    int cyc;
    req_valid = 1'b1;
    #1;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("pop_accept", {31'b0, req_ready}, 1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("pop_rsp_valid", {31'b0, rsp_valid}, 1);
    check("pop_rsp_done", {31'b0, rsp_done}, {31'b0, exp_done});
  endtask

  task automatic read(input logic [3:0] a, output logic [31:0] d);
    csr_read_valid = 1'b1;
    csr_read_addr  = a;
    @(negedge clk);
    csr_read_valid = 1'b0;
    #1;
    d = csr_read_data;
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d);
    csr_write_valid = 1'b1;
    csr_write_addr  = a;
    csr_write_data  = d;
    @(negedge clk);
    csr_write_valid = 1'b0;
  endtask

  // Scoreboard helpers for the ordering test
  task automatic push_x(input logic [15:0] x);
    push(mk(x, 16'h1, 4'h0, 16'h0, 32'h0, 32'h0));
    exp_q.push_back({16'h0, x});
  endtask

  task automatic pop_x();
    pop(1'b0);
    read(4'd0, rd);
    check("wrap_pos_x", {16'h0, rd[15:0]}, exp_q.pop_front());
  endtask

  initial begin
    int stalled;
    reset = 1'b1; stamp_valid = 1'b0; stamp_data = '0; raster_done = 1'b0;
    req_valid = 1'b0; csr_read_valid = 1'b0; csr_read_addr = '0;
    csr_write_valid = 1'b0; csr_write_addr = '0; csr_write_data = '0;
    @(negedge clk);
    do_reset();
    #1;
    check("idle_req_ready", {31'b0, req_ready}, 0);

    // Single stamp round trip
    push(mk(16'd5, 16'd7, 4'b1011, 16'd3, 32'h11, 32'hA5A5_0013));
    pop(1'b0);
    @(negedge clk);
    #1;
    check("rsp_pulse_width", {31'b0, rsp_valid}, 0);
    read(4'd0, rd);  check("t1_addr0", rd, 32'h0007_0005);
    read(4'd1, rd);  check("t1_addr1", rd, 32'h0003_000B);
    read(4'd2, rd);  check("t1_addr2", rd, 32'h0000_0011);
    read(4'd13, rd); check("t1_addr13", rd, 32'hA5A5_0013);

    // Fill to full, then pop with a push offered in the same cycle
    for (int i = 0; i < 4; i++) push(mk(16'(10 + i), 16'h20, 4'h0, 16'h0, 32'h0, 32'h0));
    #1;
    check("full_stamp_ready", {31'b0, stamp_ready}, 0);
    req_valid   = 1'b1;
    stamp_valid = 1'b1;
    stamp_data  = mk(16'd99, 16'h20, 4'h0, 16'h0, 32'h0, 32'h0);
    #1;
    check("full_no_pop_through", {31'b0, stamp_ready}, 0);
    check("full_req_ready", {31'b0, req_ready}, 1);
    @(negedge clk);
    req_valid = 1'b0; stamp_valid = 1'b0;
    #1;
    check("full_pop_rsp", {31'b0, rsp_valid}, 1);
    check("ready_after_pop", {31'b0, stamp_ready}, 1);
    read(4'd0, rd); check("full_head", rd, 32'h0020_000A);
    for (int i = 1; i < 4; i++) begin
      pop(1'b0);
      read(4'd0, rd); check("drain_order", rd, {16'h20, 16'(10 + i)});
    end
    #1;
    check("drained_empty", {31'b0, req_ready}, 0);

    // Stall while empty, then done response
    req_valid = 1'b1;
    stalled = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!req_ready) stalled++;
      @(negedge clk);
    end
    check("stall_cycles", stalled, 10);
    raster_done = 1'b1;
    #1;
    check("done_req_ready", {31'b0, req_ready}, 1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("done_rsp_valid", {31'b0, rsp_valid}, 1);
    check("done_rsp_done", {31'b0, rsp_done}, 1);
    read(4'd0, rd); check("done_set_kept", rd, 32'h0020_000D);
    do_reset();
    raster_done = 1'b0;

    // Reset mid-operation discards queued stamps and the current set
    push(mk(16'd1, 16'd1, 4'h0, 16'h0, 32'h0, 32'h0));
    push(mk(16'd2, 16'd1, 4'h0, 16'h0, 32'h0, 32'h0));
    pop(1'b0);
    do_reset();
    #1;
    check("reset_discard", {31'b0, req_ready}, 0);
    read(4'd0, rd); check("reset_cur_clear", rd, 32'h0);

    // Gradient registers
    csr_write_valid = 1'b1; csr_write_addr = 4'd14; csr_write_data = 32'hDEAD_BEEF;
    csr_read_valid  = 1'b1; csr_read_addr  = 4'd14;
    @(negedge clk);
    csr_write_valid = 1'b0; csr_read_valid = 1'b0;
    #1;
    check("grad_rw_old", csr_read_data, 32'h0);
    read(4'd14, rd); check("grad_rw_new", rd, 32'hDEAD_BEEF);
    push(mk(16'd4, 16'd6, 4'h0, 16'h0, 32'h0, 32'h0));
    pop(1'b0);
    read(4'd14, rd); check("grad_after_pop", rd, 32'hDEAD_BEEF);
    write(4'd0, 32'h1234_5678);
    read(4'd0, rd); check("addr0_ro", rd, 32'h0006_0004);
    write(4'd15, 32'hCAFE_0001);
    read(4'd15, rd); check("grad_y", rd, 32'hCAFE_0001);

    // Ordering across a pointer wrap with one simultaneous push and pop
    push_x(16'd0); push_x(16'd1); push_x(16'd2);
    pop_x(); pop_x();
    req_valid   = 1'b1;
    stamp_valid = 1'b1;
    stamp_data  = mk(16'd3, 16'h1, 4'h0, 16'h0, 32'h0, 32'h0);
    #1;
    check("pp_ready", {31'b0, req_ready & stamp_ready}, 1);
    @(negedge clk);
    req_valid = 1'b0; stamp_valid = 1'b0;
    exp_q.push_back(32'd3);
    read(4'd0, rd); check("wrap_pos_x", {16'h0, rd[15:0]}, exp_q.pop_front());
    push_x(16'd4); push_x(16'd5);
    pop_x(); pop_x(); pop_x();
    check("wrap_drained", exp_q.size(), 0);
    #1;
    check("wrap_empty", {31'b0, req_ready}, 0);

    // Push-to-pop latency with an empty FIFO
    stamp_valid = 1'b1;
    stamp_data  = mk(16'd8, 16'd9, 4'h0, 16'h0, 32'h0, 32'h0);
    req_valid   = 1'b1;
    #1;
`ifdef RASTER_STAMP_BYPASS_EN
    check("byp_req_ready", {31'b0, req_ready}, 1);
    @(negedge clk);
    stamp_valid = 1'b0; req_valid = 1'b0;
    #1;
    check("byp_rsp_valid", {31'b0, rsp_valid}, 1);
    check("byp_rsp_done", {31'b0, rsp_done}, 0);
    check("byp_fifo_empty", {31'b0, req_ready}, 0);
    read(4'd0, rd); check("byp_addr0", rd, 32'h0009_0008);
    raster_done = 1'b1;
    stamp_valid = 1'b1;
    stamp_data  = mk(16'd11, 16'd12, 4'h0, 16'h0, 32'h0, 32'h0);
    req_valid   = 1'b1;
    @(negedge clk);
    stamp_valid = 1'b0; req_valid = 1'b0;
    #1;
    check("byp_over_done_valid", {31'b0, rsp_valid}, 1);
    check("byp_over_done_done", {31'b0, rsp_done}, 0);
    read(4'd0, rd); check("byp_over_done_addr0", rd, 32'h000C_000B);
`else
    check("nobyp_req_ready", {31'b0, req_ready}, 0);
    @(negedge clk);
    stamp_valid = 1'b0;
    #1;
    check("nobyp_ready_next", {31'b0, req_ready}, 1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("nobyp_rsp_valid", {31'b0, rsp_valid}, 1);
    read(4'd0, rd); check("nobyp_addr0", rd, 32'h0009_0008);
`endif

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/raster_stamp_csr.md
# raster_stamp_csr

Consumer-side endpoint of the rasterizer stamp stream. Accepts packed `raster_stamp_t` stamps from the raster unit, buffers them in a small FIFO, and on a core pop request latches the head stamp into a `raster_csrs_t`-layout register set. The core then reads that set word-by-word through a CSR read port. It sits between the raster unit output and the core CSR unit, one instance per core.

## Interface
Parameters:
- `QUEUE_DEPTH`, 4: stamp FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `stamp_valid`  in  1  stamp offered by the raster unit.
- `stamp_data`  in  436  packed `raster_stamp_t`, field order: pos_x, pos_y, mask, bcoord_x, bcoord_y, bcoord_z, pid.
- `stamp_ready`  out  1  FIFO can accept.
- `raster_done`  in  1  raster unit has emitted its last stamp; level-held until reset.
- `req_valid`  in  1  core requests the next stamp.
- `req_ready`  out  1  request accepted this cycle.
- `rsp_valid`  out  1  single-cycle pulse: current set updated, or done reported.
- `rsp_done`  out  1  qualifies `rsp_valid`: no more stamps; current set unchanged.
- `csr_read_valid`  in  1  CSR read strobe.
- `csr_read_addr`  in  4  CSR word index.
- `csr_read_data`  out  32  read data, registered.
- `csr_write_valid`  in  1  CSR write strobe; affects only grad words.
- `csr_write_addr`  in  4  CSR word index.
- `csr_write_data`  in  32  write data.

## Operation
- Reset value of every output is 0. Reset also clears the FIFO pointers and count, the current CSR set, and the grad registers.
- Reset asserted mid-operation discards all queued stamps immediately.
- Push: a stamp is written when `stamp_valid & stamp_ready`. `stamp_ready = (count != QUEUE_DEPTH)`.
- Push while full: there is no pop-through. A full FIFO holds `stamp_ready` low even in a cycle where a pop occurs.
- Pop is accepted when `req_valid & req_ready`, with `req_ready = (count != 0) | raster_done`.
  - If `count != 0`: the head is dequeued and unpacked into the current set.
  - If `count == 0` (so `raster_done` must be 1): no state changes, and the response carries `rsp_done = 1`.
- A request arriving while the FIFO is empty and `raster_done = 0` stalls with `req_ready = 0`.
- Push and pop in the same cycle: count is unchanged, and both pointers advance modulo `QUEUE_DEPTH`.
- CSR word map and unpacking:
  - 0: `pos_y_x = {pos_y, pos_x}`.
  - 1: `pid_mask = {pid, 12'b0, mask}`.
  - 2–5: `bcoord_x[0..3]`.
  - 6–9: `bcoord_y[0..3]`.
  - 10–13: `bcoord_z[0..3]`.
  - 14: `grad_x`.
  - 15: `grad_y`.
- Writes to addresses 14/15 update grad_x/grad_y. Writes to addresses 0–13 are ignored.
- `grad_x`/`grad_y` are not touched by pops.

## Timing
- Pop accepted at edge N:
  - The current set holds the new stamp after edge N.
  - `rsp_valid` is high for the cycle following edge N only.
  - `rsp_done` is valid in that same cycle.
- Back-to-back pops are legal every cycle. Each produces one `rsp_valid` pulse.
- CSR read sampled at edge N: `csr_read_data` is valid after edge N and holds until the next read.
- Read and pop in the same cycle: the read returns the pre-pop value.
- Read and write to the same grad address in the same cycle: the read returns the old value. The new value is visible from the next read.
- Push-to-pop latency with the FIFO empty, no bypass: a stamp pushed at edge N can be popped at edge N+1 at the earliest, because `req_ready` rises after edge N.

## Configuration
- `RASTER_STAMP_BYPASS_EN` defined:
  - With the FIFO empty, `req_ready` also rises when `stamp_valid` is high.
  - A simultaneous push and pop forwards `stamp_data` directly into the current set. The FIFO is not written, so push-to-pop latency is 0 cycles.
  - Bypass takes priority over done: a stamp present with `raster_done = 1` is delivered, not `rsp_done`.
- Undefined: no combinational path from `stamp_valid` to `req_ready`. All stamps pass through the FIFO.

## Test plan
- Reset, then push one stamp (pos_x=5, pos_y=7, mask=4'b1011, pid=3, bcoord_x[0]=0x11), then pop. Required:
  - `rsp_valid=1`, `rsp_done=0`.
  - Read addr 0 returns 0x00070005; addr 1 returns 0x0003000B; addr 2 returns 0x00000011.
- Push 4 stamps with `QUEUE_DEPTH=4`. Required: `stamp_ready=0`. Then pop + offer a push in the same cycle: the push is not accepted; count goes to 3 and `stamp_ready` returns to 1.
- FIFO empty, `raster_done=0`, `req_valid=1`. Required: `req_ready` stays 0 for 10 cycles. Then assert `raster_done`: the pop is accepted, then `rsp_valid=1`, `rsp_done=1`, and addr 0 is unchanged.
- Write addr 14 = 0xDEADBEEF together with a read of addr 14: the read returns 0. The next read returns 0xDEADBEEF. A pop does not change it. A write to addr 0 does not change addr 0.
- Push 6 stamps and pop 6 across a pointer wrap, with one push+pop in the same cycle. Required: pos_x reads back 0..5 in order with no loss.
- With `RASTER_STAMP_BYPASS_EN` and the FIFO empty, assert `stamp_valid` and `req_valid` in the same cycle. Required: the pop is accepted that cycle, addr 0 shows the new stamp the next cycle, and count stays 0.
